rr_mux_arbiter: RTL and testbench
=================================

// Module: rr_mux_arbiter
// PURPOSE
//  4-requester round-robin arbiter that shares one N-bit output channel among four sources.
//  Grants one requester at a time and drives the select of an internal mux_4to1.
//  Moves up to BURST beats per grant to the consumer over a valid/ready handshake.
//  Sits between the four producers and the single downstream consumer.
// PARAMETERS
//  N      4  data width of each requester and of out_data
//  BURST  4  max beats transferred per grant before forced release (>=1)
// PORTS
//  clk        in   1     single clock; all state updates on rising edge
//  rst        in   1     synchronous, active-high reset
//  req        in   4     req[i]=1: requester i has a beat on Xi; held while more beats are pending
//  X0..X3     in   N     requester data
//  out_ready  in   1     consumer can accept a beat this cycle
//  out_valid  out  1     out_data holds a beat from the granted requester
//  out_data   out  N     = X[sel] via mux_4to1
//  sel        out  2     index of the current or last granted requester
//  ack        out  4     one-hot; ack[g]=1 in the cycle beat from requester g transfers
//  busy       out  1     1 while in GRANT
// BEHAVIOUR
//  Reset values (sync, rst dominates everything):
//   state=IDLE, ptr=3, sel=0, beat_cnt=0, out_valid=0, ack=0, busy=0
//  Transfer:
//   xfer = out_valid & out_ready
//   ack  = xfer ? onehot(sel) : 0 (combinational)
//  IDLE:
//   out_valid=0
//   if |req, then sel<=rr_pick(req,ptr), beat_cnt<=0, ->GRANT
//   Otherwise stay in IDLE
//  rr_pick:
//   Search order ptr+1, ptr+2, ptr+3, ptr+4 (mod 4); first set req bit wins
//   ptr=3 gives order 0,1,2,3
//  GRANT:
//   out_valid = req[sel]
//   if !req[sel]: ptr<=sel, ->IDLE, no ack
//   elif xfer && beat_cnt==BURST-1: ptr<=sel, ->IDLE
//   elif xfer: beat_cnt<=beat_cnt+1, stay
//   else (backpressure): hold sel, beat_cnt and out_data; no ack
//  Latency:
//   req rising in cycle t gives out_valid in cycle t+1
//   Each release costs one IDLE bubble cycle before the next grant
//  Width: beat_cnt is max(1,$clog2(BURST)) bits; it never wraps (release at BURST-1)
//  out_ready while out_valid=0 is ignored
//  out_data when out_valid=0 is X[sel] (don't-care)
//  Simultaneous requests are resolved only by rr_pick; req changes on non-granted lines are ignored during GRANT
//  rst during GRANT: no ack in that cycle, IDLE next cycle, in-flight beat dropped
// STRUCTURE
//  Shared header arb_defs.vh: state localparams (IDLE=1'b0, GRANT=1'b1), NUM_REQ=4
//  Sub-module: mux_4to1 #(.N(N)) with .S(sel), .Z(out_data); all arbitration logic stays local
// TESTING
//  1 BURST=4, req=0001, X0=8'hA5, ready=1: out_valid from cycle 1; ack[0] on 4 cycles; then IDLE, busy=0
//  2 BURST=1, req=1111, ready=1: grants 0,1,2,3,0 with one bubble between each
//  3 granted req[2] with ready=0 for 3 cycles: out_valid=1, out_data=X2 stable, ack=0, beat_cnt unchanged
//  4 req[1] drops after 2 of 4 beats: IDLE next cycle, no extra ack; next rr_pick starts at 2
//  5 rst=1 in GRANT with ready=1: ack=0 that cycle; next cycle out_valid=0, sel=0, ptr=3
//  6 ptr=3, req=1001: grant 0; after release req=1001: grant 3 (wrap check)

Source files
------------

// File: rtl/rr_mux_arbiter_pkg.sv
// ============================================================================
// Module   : rr_mux_arbiter_pkg
// Brief    : Shared state encoding, requester count and round-robin pick helper
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_mux_arbiter_pkg;

    localparam int c_NUM_REQ = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // The search starts one past the last winner, so a requester that just
    // released is considered last.
    function automatic logic [1:0] rr_pick(input logic [c_NUM_REQ-1:0] req,
                                           input logic [1:0]           ptr);
        logic [1:0] w_idx;
        logic [1:0] w_pick;
        logic       w_found;
        w_pick  = ptr;
        w_found = 1'b0;
        for (int i = 1; i <= c_NUM_REQ; i++) begin
            w_idx = ptr + 2'(i);
            if (!w_found && req[w_idx]) begin
                w_pick  = w_idx;
                w_found = 1'b1;
            end
        end
        return w_pick;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_mux_arbiter_mux_4to1.sv
// ============================================================================
// Module   : mux_4to1
// Brief    : N-bit 4-to-1 data selector driven by the arbiter grant index
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_4to1 #(
    parameter int N = 4
) (
    input  logic [N-1:0] X0,
    input  logic [N-1:0] X1,
    input  logic [N-1:0] X2,
    input  logic [N-1:0] X3,
    input  logic [1:0]   S,
    output logic [N-1:0] Z
);

    always_comb begin
        Z = X0;
        case (S)
            2'd0:    Z = X0;
            2'd1:    Z = X1;
            2'd2:    Z = X2;
            default: Z = X3;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
// ============================================================================
// Module   : rr_mux_arbiter
// Brief    : 4-way round-robin arbiter sharing one valid/ready channel, with
//            up to BURST beats per grant
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [c_NUM_REQ-1:0] req,
    input  logic [N-1:0]         X0,
    input  logic [N-1:0]         X1,
    input  logic [N-1:0]         X2,
    input  logic [N-1:0]         X3,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [N-1:0]         out_data,
    output logic [1:0]           sel,
    output logic [c_NUM_REQ-1:0] ack,
    output logic                 busy
);

    localparam int              c_CW   = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(BURST - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_ptr;
    logic [1:0]      w_ptr_nxt;
    logic [1:0]      r_sel;
    logic [1:0]      w_sel_nxt;
    logic [c_CW-1:0] r_beat_cnt;
    logic [c_CW-1:0] w_beat_cnt_nxt;
    logic            w_xfer;

    // Reset masks the handshake in the same cycle so an in-flight beat is dropped.
    assign out_valid = !rst && (r_state == GRANT) && req[r_sel];
    assign busy      = !rst && (r_state == GRANT);
    assign w_xfer    = out_valid && out_ready;
    assign ack       = w_xfer ? (c_NUM_REQ'(1) << r_sel) : '0;
    assign sel       = r_sel;

    mux_4to1 #(.N(N)) u_mux (
        .X0 (X0),
        .X1 (X1),
        .X2 (X2),
        .X3 (X3),
        .S  (r_sel),
        .Z  (out_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= 2'd3;
            r_sel      <= 2'd0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_sel      <= w_sel_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_sel_nxt      = r_sel;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_sel_nxt      = rr_pick(req, r_ptr);
                    w_beat_cnt_nxt = '0;
                    w_state_nxt    = GRANT;
                end
            end
            GRANT: begin
                if (!req[r_sel]) begin
                    w_ptr_nxt   = r_sel;
                    w_state_nxt = IDLE;
                end else if (w_xfer && (r_beat_cnt == c_LAST)) begin
                    w_ptr_nxt   = r_sel;
                    w_state_nxt = IDLE;
                end else if (w_xfer) begin
                    w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
// ============================================================================
// Module   : tb_rr_mux_arbiter
// Brief    : Directed vector table on a BURST=4 instance plus a BURST=1
//            fairness sequence
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_mux_arbiter;

    localparam int c_N = 8;

    logic           clk;
    logic [c_N-1:0] x0, x1, x2, x3;

    logic           rst4, rdy4, valid4, busy4;
    logic [3:0]     req4, ack4;
    logic [1:0]     sel4;
    logic [c_N-1:0] data4;

    logic           rst1, rdy1, valid1, busy1;
    logic [3:0]     req1, ack1;
    logic [1:0]     sel1;
    logic [c_N-1:0] data1;

    int total = 0;
    int bad   = 0;

    rr_mux_arbiter #(.N(c_N), .BURST(4)) u_dut4 (
        .clk(clk), .rst(rst4), .req(req4),
        .X0(x0), .X1(x1), .X2(x2), .X3(x3),
        .out_ready(rdy4), .out_valid(valid4), .out_data(data4),
        .sel(sel4), .ack(ack4), .busy(busy4)
    );

    rr_mux_arbiter #(.N(c_N), .BURST(1)) u_dut1 (
        .clk(clk), .rst(rst1), .req(req1),
        .X0(x0), .X1(x1), .X2(x2), .X3(x3),
        .out_ready(rdy1), .out_valid(valid1), .out_data(data1),
        .sel(sel1), .ack(ack1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic           rst;
        logic [3:0]     req;
        logic           rdy;
        logic           exp_valid;
        logic [1:0]     exp_sel;
        logic           chk_sel;
        logic [3:0]     exp_ack;
        logic           exp_busy;
        logic [c_N-1:0] exp_data;
    } vec_t;

    vec_t tbl[29];

    function automatic vec_t mk(logic r, logic [3:0] q, logic y, logic v, logic [1:0] s,
                                logic cs, logic [3:0] a, logic b, logic [c_N-1:0] d);
        vec_t t;
        t.rst = r; t.req = q; t.rdy = y; t.exp_valid = v; t.exp_sel = s;
        t.chk_sel = cs; t.exp_ack = a; t.exp_busy = b; t.exp_data = d;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    initial begin
        x0 = 8'hA5; x1 = 8'h3C; x2 = 8'h7E; x3 = 8'hC1;
        rst4 = 1'b1; req4 = '0; rdy4 = 1'b0;
        rst1 = 1'b1; req1 = '0; rdy1 = 1'b0;

        //                rst req      rdy val sel  cs  ack      busy data
        tbl[0]  = mk(1'b1, 4'b0000, 1'b0, 0, 2'd0, 1, 4'b0000, 0, 8'h00);
        tbl[1]  = mk(1'b0, 4'b0001, 1'b1, 0, 2'd0, 1, 4'b0000, 0, 8'h00);
        tbl[2]  = mk(1'b0, 4'b0001, 1'b1, 1, 2'd0, 1, 4'b0001, 1, 8'hA5);
        tbl[3]  = mk(1'b0, 4'b0001, 1'b1, 1, 2'd0, 1, 4'b0001, 1, 8'hA5);
        tbl[4]  = mk(1'b0, 4'b0001, 1'b1, 1, 2'd0, 1, 4'b0001, 1, 8'hA5);
        tbl[5]  = mk(1'b0, 4'b0001, 1'b1, 1, 2'd0, 1, 4'b0001, 1, 8'hA5);
        tbl[6]  = mk(1'b0, 4'b0000, 1'b1, 0, 2'd0, 1, 4'b0000, 0, 8'h00);
        tbl[7]  = mk(1'b0, 4'b0100, 1'b1, 0, 2'd0, 1, 4'b0000, 0, 8'h00);
        tbl[8]  = mk(1'b0, 4'b0100, 1'b0, 1, 2'd2, 1, 4'b0000, 1, 8'h7E);
        tbl[9]  = mk(1'b0, 4'b0100, 1'b0, 1, 2'd2, 1, 4'b0000, 1, 8'h7E);
        tbl[10] = mk(1'b0, 4'b0100, 1'b0, 1, 2'd2, 1, 4'b0000, 1, 8'h7E);
        tbl[11] = mk(1'b0, 4'b0100, 1'b1, 1, 2'd2, 1, 4'b0100, 1, 8'h7E);
        tbl[12] = mk(1'b0, 4'b0100, 1'b1, 1, 2'd2, 1, 4'b0100, 1, 8'h7E);
        tbl[13] = mk(1'b0, 4'b0100, 1'b1, 1, 2'd2, 1, 4'b0100, 1, 8'h7E);
        tbl[14] = mk(1'b0, 4'b0100, 1'b1, 1, 2'd2, 1, 4'b0100, 1, 8'h7E);
        tbl[15] = mk(1'b0, 4'b0000, 1'b1, 0, 2'd2, 1, 4'b0000, 0, 8'h00);
        tbl[16] = mk(1'b0, 4'b0010, 1'b1, 0, 2'd2, 1, 4'b0000, 0, 8'h00);
        tbl[17] = mk(1'b0, 4'b0010, 1'b1, 1, 2'd1, 1, 4'b0010, 1, 8'h3C);
        tbl[18] = mk(1'b0, 4'b0010, 1'b1, 1, 2'd1, 1, 4'b0010, 1, 8'h3C);
        tbl[19] = mk(1'b0, 4'b0000, 1'b1, 0, 2'd1, 1, 4'b0000, 1, 8'h00);
        tbl[20] = mk(1'b0, 4'b1111, 1'b1, 0, 2'd1, 1, 4'b0000, 0, 8'h00);
        tbl[21] = mk(1'b0, 4'b1111, 1'b0, 1, 2'd2, 1, 4'b0000, 1, 8'h7E);
        tbl[22] = mk(1'b1, 4'b1111, 1'b1, 0, 2'd2, 0, 4'b0000, 0, 8'h00);
        tbl[23] = mk(1'b0, 4'b0000, 1'b1, 0, 2'd0, 1, 4'b0000, 0, 8'h00);
        tbl[24] = mk(1'b0, 4'b1001, 1'b1, 0, 2'd0, 1, 4'b0000, 0, 8'h00);
        tbl[25] = mk(1'b0, 4'b1001, 1'b1, 1, 2'd0, 1, 4'b0001, 1, 8'hA5);
        tbl[26] = mk(1'b0, 4'b0000, 1'b1, 0, 2'd0, 1, 4'b0000, 1, 8'h00);
        tbl[27] = mk(1'b0, 4'b1001, 1'b1, 0, 2'd0, 1, 4'b0000, 0, 8'h00);
        tbl[28] = mk(1'b0, 4'b1001, 1'b1, 1, 2'd3, 1, 4'b1000, 1, 8'hC1);

        repeat (3) @(posedge clk);

        // Each row is one cycle: drive after the falling edge, sample 1 ns later.
        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            rst4 = tbl[i].rst;
            req4 = tbl[i].req;
            rdy4 = tbl[i].rdy;
            #1;
            chk("valid", i, 32'(valid4), 32'(tbl[i].exp_valid));
            chk("ack",   i, 32'(ack4),   32'(tbl[i].exp_ack));
            chk("busy",  i, 32'(busy4),  32'(tbl[i].exp_busy));
            if (tbl[i].chk_sel)
                chk("sel", i, 32'(sel4), 32'(tbl[i].exp_sel));
            if (tbl[i].exp_valid)
                chk("data", i, 32'(data4), 32'(tbl[i].exp_data));
        end

        // BURST=1 with all requesters active: grants 0,1,2,3,0 separated by bubbles.
        @(negedge clk);
        rst1 = 1'b0;
        req1 = 4'b1111;
        rdy1 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            logic [1:0]     g;
            logic [c_N-1:0] xd;
            logic           active;
            if (k > 0) @(negedge clk);
            #1;
            g      = 2'((k / 2) % 4);
            active = (k % 2) == 1;
            case (g)
                2'd0:    xd = 8'hA5;
                2'd1:    xd = 8'h3C;
                2'd2:    xd = 8'h7E;
                default: xd = 8'hC1;
            endcase
            chk("b1_valid", k, 32'(valid1), 32'(active));
            chk("b1_busy",  k, 32'(busy1),  32'(active));
            chk("b1_ack",   k, 32'(ack1),   active ? 32'(4'b0001 << g) : 32'd0);
            if (active) begin
                chk("b1_sel",  k, 32'(sel1),  32'(g));
                chk("b1_data", k, 32'(data1), 32'(xd));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
